// File: rtl/md_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package md_pkg;

  // Operation select as presented by the control unit.
  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } md_op_e;

  // Sequencer states.
  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_FIX  = 2'd2
  } md_state_e;

  // True for the two's-complement variants.
  function automatic logic md_is_signed(input md_op_e op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

  // True for either divide variant.
  function automatic logic md_is_div(input md_op_e op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_sign_fix.sv
// Conditional two's-complement negate, used both to take operand
// magnitudes and to restore the sign of results.
module md_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] val_i,
  input  logic         neg_i,
  output logic [W-1:0] res_o
);

  assign res_o = neg_i ? (~val_i + W'(1)) : val_i;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit holding the architectural HI/LO pair.
// One bit of product or quotient is produced per cycle on unsigned
// magnitudes; signs are applied only when operands are latched and when
// results are written back.
module mult_div_unit
  import md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             mthi,
  input  logic             mtlo,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  md_op_e              op_in;
  logic                in_signed;
  logic                in_sign_a;
  logic                in_sign_b;
  logic [WIDTH-1:0]    in_mag_a;
  logic [WIDTH-1:0]    in_mag_b;

  md_state_e           state_q;
  md_op_e              op_q;
  logic [WIDTH-1:0]    mag_a_q;
  logic [WIDTH-1:0]    mag_b_q;
  logic                sign_a_q;
  logic                sign_b_q;
  logic [2*WIDTH-1:0]  acc_q;
  logic [2*WIDTH-1:0]  acc_d;
  logic [CNT_W-1:0]    cnt_q;
  logic                busy_q;
  logic                done_q;
  logic                dbz_q;
  logic [WIDTH-1:0]    hi_q;
  logic [WIDTH-1:0]    lo_q;

  logic [WIDTH:0]      mul_sum;
  logic [WIDTH:0]      div_trial;
  logic                res_neg;
  logic [2*WIDTH-1:0]  prod_fix;
  logic [WIDTH-1:0]    quo_fix;
  logic [WIDTH-1:0]    rem_fix;

  assign op_in     = md_op_e'(op);
  assign in_signed = md_is_signed(op_in);
  assign in_sign_a = in_signed & src_a[WIDTH-1];
  assign in_sign_b = in_signed & src_b[WIDTH-1];
  // Quotient and product share a sign; the remainder follows the dividend.
  assign res_neg   = sign_a_q ^ sign_b_q;

  md_sign_fix #(.W(WIDTH)) u_mag_a (
    .val_i (src_a),
    .neg_i (in_sign_a),
    .res_o (in_mag_a)
  );

  md_sign_fix #(.W(WIDTH)) u_mag_b (
    .val_i (src_b),
    .neg_i (in_sign_b),
    .res_o (in_mag_b)
  );

  md_sign_fix #(.W(2*WIDTH)) u_fix_prod (
    .val_i (acc_q),
    .neg_i (res_neg),
    .res_o (prod_fix)
  );

  md_sign_fix #(.W(WIDTH)) u_fix_quo (
    .val_i (acc_q[WIDTH-1:0]),
    .neg_i (res_neg),
    .res_o (quo_fix)
  );

  md_sign_fix #(.W(WIDTH)) u_fix_rem (
    .val_i (acc_q[2*WIDTH-1:WIDTH]),
    .neg_i (sign_a_q),
    .res_o (rem_fix)
  );

  // One shift-add or restoring-divide step on the accumulator.
  // Multiply: acc = {partial product, remaining multiplier bits}.
  // Divide:   acc = {partial remainder, remaining dividend / quotient bits}.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    acc_d     = acc_q;
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                {1'b0, (acc_q[0] ? mag_a_q : '0)};
    div_trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, mag_b_q};
    if (md_is_div(op_q)) begin
      // A shifted remainder with its top bit set always exceeds the
      // divisor, so dropping that bit on the restore path is safe.
      if (!div_trial[WIDTH]) begin
        acc_d = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_d = {mul_sum, acc_q[WIDTH-1:1]};
    end
  end

  // Sequencer, datapath registers and HI/LO with registered status outputs.
  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values; rst is asynchronous and clears everything,
  // discarding any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= MD_IDLE;
      op_q     <= MD_MULT;
      mag_a_q  <= '0;
      mag_b_q  <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
      case (state_q)
        MD_IDLE: begin
          if (start) begin
            op_q     <= op_in;
            mag_a_q  <= in_mag_a;
            mag_b_q  <= in_mag_b;
            sign_a_q <= in_sign_a;
            sign_b_q <= in_sign_b;
            acc_q    <= {{WIDTH{1'b0}}, (md_is_div(op_in) ? in_mag_a : in_mag_b)};
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= MD_RUN;
          end else begin
            if (mthi) hi_q <= src_a;
            if (mtlo) lo_q <= src_a;
          end
        end
        MD_RUN: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) state_q <= MD_FIX;
        end
        MD_FIX: begin
          if (md_is_div(op_q)) begin
            if (mag_b_q == '0) begin
              dbz_q <= 1'b1;
            end else begin
              hi_q <= rem_fix;
              lo_q <= quo_fix;
            end
          end else begin
            {hi_q, lo_q} <= prod_fix;
          end
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= MD_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= MD_IDLE;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule
